// File: rtl/graphic_scaled.sv
// VGA scan-out with integer upscale of a BGR555 framebuffer, centred on a border colour.
// The H/V counters drive a multiplier-free address generator. Control bits are delayed
// MEM_LAT cycles so they meet the returning RAM data, then registered once at the pins.
module graphic_scaled #(
  parameter int          FB_W    = 240,
  parameter int          FB_H    = 160,
  parameter int          SCALE   = 2,
  parameter int          X_OFF   = 80,
  parameter int          Y_OFF   = 80,
  parameter int          H_VIS   = 640,
  parameter int          H_FP    = 16,
  parameter int          H_SYNC  = 96,
  parameter int          H_BP    = 48,
  parameter int          V_VIS   = 480,
  parameter int          V_FP    = 10,
  parameter int          V_SYNC  = 2,
  parameter int          V_BP    = 33,
  parameter int          MEM_LAT = 1,
  parameter logic [14:0] BORDER  = 15'h0000,
  parameter int          AW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] addr,
  input  logic [15:0]   data,
  output logic [7:0]    R,
  output logic [7:0]    G,
  output logic [7:0]    B,
  output logic          HS,
  output logic          VS,
  output logic          vga_clk,
  output logic          vga_black_n,
  output logic          vga_sync_n,
  output logic          vblank,
  output logic          frame_start
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int FXW   = (FB_W > 1) ? $clog2(FB_W) : 1;
  localparam int SW    = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [HW-1:0] HS_LO  = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_HI  = HW'(H_VIS + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_VEND = HW'(H_VIS);
  localparam logic [HW-1:0] X_LO   = HW'(X_OFF);
  localparam logic [HW-1:0] X_HI   = HW'(X_OFF + FB_W * SCALE);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
  localparam logic [VW-1:0] VS_LO  = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_HI  = VW'(V_VIS + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_VEND = VW'(V_VIS);
  localparam logic [VW-1:0] Y_LO   = VW'(Y_OFF);
  localparam logic [VW-1:0] Y_HI   = VW'(Y_OFF + FB_H * SCALE);
  localparam logic [SW-1:0] SUB_LAST = SW'(SCALE - 1);
  localparam logic [AW-1:0] ROW_STEP = AW'(FB_W);

  // Control bits kept active-high so a cleared stage reads as "idle, syncs inactive".
  typedef struct packed {
    logic hs_on;
    logic vs_on;
    logic vis;
    logic img;
    logic vb;
  } ctl_t;

  logic [HW-1:0]  hcnt_q, hcnt_d;
  logic [VW-1:0]  vcnt_q, vcnt_d;
  logic [FXW-1:0] fx_q, fx_d;
  logic [SW-1:0]  sub_q, sub_d;
  logic [SW-1:0]  vsub_q, vsub_d;
  logic [AW-1:0]  row_base_q, row_base_d;
  ctl_t           pipe_q [MEM_LAT];
  ctl_t           pipe_d [MEM_LAT];
  ctl_t           cur, tap;
  logic [7:0]     r_q, r_d, g_q, g_d, b_q, b_d;
  logic           hs_q, hs_d, vs_q, vs_d;
  logic           black_n_q, black_n_d, vblank_q, vblank_d, fs_q, fs_d;
  logic           h_end, v_end, x_in, y_in, inimg;
  logic [14:0]    pix;
  logic           data_unused;

  function automatic logic [7:0] exp5(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction

  // Raster counters, image window decode and read address generation.
  always_comb begin
    h_end  = (hcnt_q == H_LAST);
    v_end  = (vcnt_q == V_LAST);
    x_in   = (hcnt_q >= X_LO) && (hcnt_q < X_HI);
    y_in   = (vcnt_q >= Y_LO) && (vcnt_q < Y_HI);
    inimg  = x_in && y_in;
    addr   = inimg ? (row_base_q + AW'(fx_q)) : '0;
    hcnt_d = h_end ? '0 : hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (h_end) vcnt_d = v_end ? '0 : vcnt_q + 1'b1;
    fx_d  = fx_q;
    sub_d = sub_q;
    if (h_end) begin
      fx_d  = '0;
      sub_d = '0;
    end else if (inimg) begin
      if (sub_q == SUB_LAST) begin
        sub_d = '0;
        fx_d  = fx_q + 1'b1;
      end else begin
        sub_d = sub_q + 1'b1;
      end
    end
    row_base_d = row_base_q;
    vsub_d     = vsub_q;
    if (h_end) begin
      if (v_end) begin
        row_base_d = '0;
        vsub_d     = '0;
      end else if (y_in) begin
        if (vsub_q == SUB_LAST) begin
          vsub_d     = '0;
          row_base_d = row_base_q + ROW_STEP;
        end else begin
          vsub_d = vsub_q + 1'b1;
        end
      end
    end
  end

  // Control delay line matching the RAM read latency.
  always_comb begin
    cur.hs_on = (hcnt_q >= HS_LO) && (hcnt_q < HS_HI);
    cur.vs_on = (vcnt_q >= VS_LO) && (vcnt_q < VS_HI);
    cur.vis   = (hcnt_q < H_VEND) && (vcnt_q < V_VEND);
    cur.img   = inimg;
    cur.vb    = (vcnt_q >= V_VEND);
    pipe_d[0] = cur;
    for (int i = 1; i < MEM_LAT; i++) pipe_d[i] = pipe_q[i-1];
  end

  // Pixel selection, colour expansion and sync outputs for the pin register.
  always_comb begin
    tap  = pipe_q[MEM_LAT-1];
    pix  = tap.img ? data[14:0] : BORDER;
    r_d  = tap.vis ? exp5(pix[4:0])   : 8'h00;
    g_d  = tap.vis ? exp5(pix[9:5])   : 8'h00;
    b_d  = tap.vis ? exp5(pix[14:10]) : 8'h00;
    hs_d = ~tap.hs_on;
    vs_d = ~tap.vs_on;
    black_n_d = tap.vis;
    vblank_d  = tap.vb;
    fs_d      = tap.vb & ~vblank_q;
  end

  // All state, synchronously cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      fx_q       <= '0;
      sub_q      <= '0;
      vsub_q     <= '0;
      row_base_q <= '0;
      for (int i = 0; i < MEM_LAT; i++) pipe_q[i] <= '0;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      black_n_q  <= 1'b0;
      vblank_q   <= 1'b0;
      fs_q       <= 1'b0;
    end else begin
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      fx_q       <= fx_d;
      sub_q      <= sub_d;
      vsub_q     <= vsub_d;
      row_base_q <= row_base_d;
      pipe_q     <= pipe_d;
      r_q        <= r_d;
      g_q        <= g_d;
      b_q        <= b_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      black_n_q  <= black_n_d;
      vblank_q   <= vblank_d;
      fs_q       <= fs_d;
    end
  end

  assign data_unused = data[15];
  assign R           = r_q;
  assign G           = g_q;
  assign B           = b_q;
  assign HS          = hs_q;
  assign VS          = vs_q;
  assign vga_black_n = black_n_q;
  assign vblank      = vblank_q;
  assign frame_start = fs_q;
  assign vga_clk     = clk;
  assign vga_sync_n  = 1'b1;

endmodule

// File: tb/tb_graphic_scaled.sv
// Bench for graphic_scaled on a shrunken raster (20x12 clocks per frame) so whole
// frames fit in a short run. Memory model returns addr[14:0] after MEM_LAT cycles.
module tb_graphic_scaled;

  localparam int FB_W = 4, FB_H = 3, SCALE = 2, X_OFF = 2, Y_OFF = 1;
  localparam int H_VIS = 12, H_FP = 2, H_SYNC = 3, H_BP = 3;
  localparam int V_VIS = 8, V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam int H_TOT = 20, V_TOT = 12;
  localparam int LAT = 3;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] addr;
  logic [15:0]   data;
  logic [7:0]    R, G, B;
  logic          HS, VS, vga_clk, vga_black_n, vga_sync_n, vblank, frame_start;

  int vectors = 0;
  int errors  = 0;
  int th = 0, tv = 0;
  int mode = 0;
  logic [AW-1:0] mp [LAT];

  graphic_scaled #(
    .FB_W(FB_W), .FB_H(FB_H), .SCALE(SCALE), .X_OFF(X_OFF), .Y_OFF(Y_OFF),
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .MEM_LAT(LAT), .BORDER(15'h7C1F), .AW(AW)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .R(R), .G(G), .B(B),
    .HS(HS), .VS(VS), .vga_clk(vga_clk), .vga_black_n(vga_black_n),
    .vga_sync_n(vga_sync_n), .vblank(vblank), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Raster position model: (th,tv) is the counter position of the current cycle.
  always @(posedge clk) begin
    if (rst) begin
      th <= 0;
      tv <= 0;
    end else if (th == H_TOT - 1) begin
      th <= 0;
      tv <= (tv == V_TOT - 1) ? 0 : tv + 1;
    end else begin
      th <= th + 1;
    end
  end

  // Framebuffer RAM with LAT cycles of read latency.
  always @(posedge clk) begin
    mp[0] <= addr;
    for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
  end

  always_comb begin
    data = {1'b0, mp[LAT-1][14:0]};
    if (mode == 1) data = 16'h7FFF;
  end

  typedef struct {
    int         h;
    int         v;
    int         a;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       bn;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    errors++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  task automatic wait_pos(input int h, input int v);
    bit found = 0;
    for (int n = 0; n < 400 && !found; n++) begin
      if (th == h && tv == v) found = 1;
      else @(negedge clk);
    end
    if (!found) timeout("wait_pos");
  endtask

  function automatic logic sig(input int which);
    return (which == 0) ? HS : VS;
  endfunction

  // Counts negedges until the chosen sync reaches lvl after having been at the other level.
  task automatic wait_sig(input int which, input logic lvl, output int cyc);
    logic prev, cur;
    bit   found = 0;
    prev = sig(which);
    cyc  = 0;
    for (int n = 0; n < 600 && !found; n++) begin
      @(negedge clk);
      cyc++;
      cur = sig(which);
      if (prev !== lvl && cur === lvl) found = 1;
      prev = cur;
    end
    if (!found) timeout((which == 0) ? "hs_edge" : "vs_edge");
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_hs"}, HS, 1);
    check({tag, "_vs"}, VS, 1);
    check({tag, "_rgb"}, {R, G, B}, 0);
    check({tag, "_black_n"}, vga_black_n, 0);
    check({tag, "_vblank"}, vblank, 0);
    check({tag, "_fs"}, frame_start, 0);
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < 15; i++) begin
      wait_pos(tbl[i].h, tbl[i].v);
      check($sformatf("%s_addr_%0d", tag, i), addr, tbl[i].a);
      repeat (LAT + 1) @(negedge clk);
      check($sformatf("%s_r_%0d", tag, i), R, tbl[i].r);
      check($sformatf("%s_g_%0d", tag, i), G, tbl[i].g);
      check($sformatf("%s_b_%0d", tag, i), B, tbl[i].b);
      check($sformatf("%s_bn_%0d", tag, i), vga_black_n, tbl[i].bn);
    end
  endtask

  initial begin
    int c1, c2, pulses, wide, misal;
    logic prev_fs, prev_vb;

    tbl[0]  = '{2, 1, 0, 8'h00, 8'h00, 8'h00, 1'b1};
    tbl[1]  = '{3, 1, 0, 8'h00, 8'h00, 8'h00, 1'b1};
    tbl[2]  = '{4, 1, 1, 8'h08, 8'h00, 8'h00, 1'b1};
    tbl[3]  = '{9, 1, 3, 8'h18, 8'h00, 8'h00, 1'b1};
    tbl[4]  = '{2, 2, 0, 8'h00, 8'h00, 8'h00, 1'b1};
    tbl[5]  = '{2, 3, 4, 8'h21, 8'h00, 8'h00, 1'b1};
    tbl[6]  = '{8, 4, 7, 8'h39, 8'h00, 8'h00, 1'b1};
    tbl[7]  = '{6, 5, 10, 8'h52, 8'h00, 8'h00, 1'b1};
    tbl[8]  = '{9, 6, 11, 8'h5A, 8'h00, 8'h00, 1'b1};
    tbl[9]  = '{1, 1, 0, 8'hFF, 8'h00, 8'hFF, 1'b1};
    tbl[10] = '{10, 3, 0, 8'hFF, 8'h00, 8'hFF, 1'b1};
    tbl[11] = '{5, 0, 0, 8'hFF, 8'h00, 8'hFF, 1'b1};
    tbl[12] = '{5, 7, 0, 8'hFF, 8'h00, 8'hFF, 1'b1};
    tbl[13] = '{12, 3, 0, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[14] = '{5, 8, 0, 8'h00, 8'h00, 8'h00, 1'b0};

    // Reset held for three edges, released at a negedge; this cycle is pixel (0,0).
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle("rst0");
    check("rst_addr", addr, 0);
    check("sync_n", vga_sync_n, 1);
    @(negedge clk);
    check_idle("rst1");

    // Line timing: fall reached 18 cycles after (0,0) = hcnt 14 + LAT + 1.
    wait_sig(0, 1'b0, c1);
    check("hs_fall_delay", c1 + 1, 18);
    wait_sig(0, 1'b1, c1);
    check("hs_low_len", c1, H_SYNC);
    wait_sig(0, 1'b0, c2);
    check("line_period", c1 + c2, H_TOT);

    // Frame timing: VS falls at pins on position (4,9).
    wait_sig(1, 1'b0, c1);
    check("vs_fall_pos", tv * H_TOT + th, 9 * H_TOT + 4);
    wait_sig(1, 1'b1, c1);
    check("vs_low_len", c1, V_SYNC * H_TOT);
    wait_sig(1, 1'b0, c2);
    check("frame_period", c1 + c2, H_TOT * V_TOT);

    // frame_start over exactly three frames.
    pulses = 0; wide = 0; misal = 0;
    prev_fs = frame_start;
    prev_vb = vblank;
    for (int n = 0; n < 3 * H_TOT * V_TOT; n++) begin
      @(negedge clk);
      if (frame_start) begin
        pulses++;
        if (prev_fs) wide++;
        if (!vblank || prev_vb || (tv * H_TOT + th) != (8 * H_TOT + 4)) misal++;
      end
      prev_fs = frame_start;
      prev_vb = vblank;
    end
    check("fs_count", pulses, 3);
    check("fs_wide", wide, 0);
    check("fs_misaligned", misal, 0);

    run_table("img");

    mode = 1;
    wait_pos(5, 3);
    repeat (LAT + 1) @(negedge clk);
    check("white_rgb", {R, G, B}, 24'hFFFFFF);
    mode = 0;

    // One-cycle reset in the middle of the image.
    wait_pos(7, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("midrst");
    check("midrst_addr", addr, 0);
    wait_sig(0, 1'b0, c1);
    check("midrst_hs_delay", c1, 18);
    wait_sig(1, 1'b0, c1);
    check("midrst_vs_pos", tv * H_TOT + th, 9 * H_TOT + 4);
    run_table("post");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
